// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, scoreboard entry and forwarding encodings for the MIPS hazard logic
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, dest: 5'd0, is_load: 1'b0};

    function automatic logic src_hit(input logic [4:0] src, input sb_entry_t e);
        return e.valid && (e.dest == src);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational source/destination decode of the IF/ID instruction
module instr_decode
    import mips_pkg::*;
(
    input  logic [31:0] ifid_ir,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic        use_rs,
    output logic        use_rt,
    output logic [4:0]  dest,
    output logic        dest_valid,
    output logic        is_load
);

    logic [5:0] opcode;
    logic       writes;
    logic       unused;

    assign opcode = ifid_ir[31:26];
    assign rs     = ifid_ir[25:21];
    assign rt     = ifid_ir[20:16];
    assign unused = ^ifid_ir[10:0];

    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        dest    = 5'd0;
        writes  = 1'b0;
        is_load = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                dest   = ifid_ir[15:11];
                writes = (ifid_ir != 32'd0);
            end
            OP_LW: begin
                use_rs  = 1'b1;
                dest    = rt;
                writes  = 1'b1;
                is_load = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_ADDI: begin
                use_rs = 1'b1;
                dest   = rt;
                writes = 1'b1;
            end
            default: ;
        endcase
    end

    // $0 is hardwired, so a write to it can never create a dependency
    assign dest_valid = writes && (dest != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW stall / taken-branch flush controller; HAZARD_FWD_EN enables forwarding selects
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      ifid_ir,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [4:0] rs, rt, dest;
    logic       use_rs, use_rt, dest_valid, is_load;
    sb_entry_t  sb [3];
    sb_entry_t  id_entry;
    logic       hazard, stall;

    instr_decode u_decode (
        .ifid_ir    (ifid_ir),
        .rs         (rs),
        .rt         (rt),
        .use_rs     (use_rs),
        .use_rt     (use_rt),
        .dest       (dest),
        .dest_valid (dest_valid),
        .is_load    (is_load)
    );

    assign id_entry = '{valid: dest_valid, dest: dest, is_load: is_load};

`ifdef HAZARD_FWD_EN
    // Only a load still in ID/EX cannot be forwarded in time
    assign hazard = (use_rs && src_hit(rs, sb[0]) && sb[0].is_load)
                 || (use_rt && src_hit(rt, sb[0]) && sb[0].is_load);
`else
    assign hazard = (use_rs && (src_hit(rs, sb[0]) || src_hit(rs, sb[1]) || src_hit(rs, sb[2])))
                 || (use_rt && (src_hit(rt, sb[0]) || src_hit(rt, sb[1]) || src_hit(rt, sb[2])));
`endif

    assign stall = hazard && !branch_taken && !reset;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!reset) begin
            if (branch_taken) begin
                idex_bubble = 1'b1;
                ifid_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            sb[0] <= SB_EMPTY;
            sb[1] <= SB_EMPTY;
            sb[2] <= SB_EMPTY;
        end else begin
            // The branch itself sits in EX/MEM and moves on; younger wrong-path entries die
            sb[2] <= sb[1];
            sb[1] <= branch_taken ? SB_EMPTY : sb[0];
            sb[0] <= (branch_taken || stall) ? SB_EMPTY : id_entry;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (branch_taken && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

`ifdef HAZARD_FWD_EN
    logic [1:0] fwd_a_q, fwd_b_q;
    logic       unused;

    // Evaluated one stage early: sb[0] becomes EX/MEM and sb[1] becomes MEM/WB at the edge
    function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src,
                                           input sb_entry_t e0, input sb_entry_t e1);
        if (use_src && src_hit(src, e0) && !e0.is_load)
            return FWD_EXMEM;
        else if (use_src && src_hit(src, e1))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_ff @(negedge clock) begin
        if (reset || stall || branch_taken) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_sel(use_rs, rs, sb[0], sb[1]);
            fwd_b_q <= fwd_sel(use_rt, rt, sb[0], sb[1]);
        end
    end

    assign fwd_a  = fwd_a_q;
    assign fwd_b  = fwd_b_q;
    assign unused = sb[1].is_load ^ sb[2].is_load;
`else
    logic unused;

    assign fwd_a  = FWD_RF;
    assign fwd_b  = FWD_RF;
    assign unused = sb[0].is_load ^ sb[1].is_load ^ sb[2].is_load;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed-vector bench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] LW_8     = 32'h8C08_0000;
    localparam logic [31:0] LW_9     = 32'h8C09_0004;
    localparam logic [31:0] LW_12    = 32'h8C0C_0000;
    localparam logic [31:0] SLT_10   = 32'h0109_502A;
    localparam logic [31:0] SUB_10   = 32'h0109_5022;
    localparam logic [31:0] ADD_11   = 32'h014A_5820;
    localparam logic [31:0] ADD_13   = 32'h018C_6820;
    localparam logic [31:0] SW_12    = 32'hAC0C_0000;
    localparam logic [31:0] BEQ_10   = 32'h1140_0003;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ifid_ir;
    logic        branch_taken;
    logic        pc_write, ifid_write, idex_bubble, ifid_flush, exmem_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count, flush_count;

    int vectors = 0;
    int errors  = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .ifid_ir      (ifid_ir),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .exmem_flush  (exmem_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge_wait();
        @(negedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] ir);
        ifid_ir = ir;
        @(posedge clock);
        edge_wait();
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) issue(NOP);
    endtask

    task automatic run_consumer(input string tag, input logic [31:0] ir, input int nst);
        for (int i = 0; i <= nst; i++) begin
            ifid_ir = ir;
            @(posedge clock);
            check({tag, ".pc_write"}, pc_write, (i < nst) ? 1'b0 : 1'b1);
            check({tag, ".bubble"}, idex_bubble, (i < nst) ? 1'b1 : 1'b0);
            edge_wait();
        end
        exp_stall += nst;
        check({tag, ".stall_count"}, stall_count, exp_stall);
    endtask

    initial begin
        reset        = 1'b1;
        branch_taken = 1'b0;
        ifid_ir      = SLT_10;
        @(posedge clock);
        check("rst.pc_write", pc_write, 1);
        check("rst.ifid_write", ifid_write, 1);
        check("rst.bubble", idex_bubble, 0);
        check("rst.ifid_flush", ifid_flush, 0);
        check("rst.exmem_flush", exmem_flush, 0);
        edge_wait();
        check("rst.stall_count", stall_count, 0);
        check("rst.flush_count", flush_count, 0);
        check("rst.fwd_a", fwd_a, 0);
        check("rst.fwd_b", fwd_b, 0);
        reset = 1'b0;

        issue(LW_8);
        run_consumer("dist1", SLT_10, FWD ? 1 : 3);

        for (int d = 2; d <= 4; d++) begin
            drain();
            issue(LW_8);
            for (int k = 1; k < d; k++) issue(NOP);
            run_consumer($sformatf("dist%0d", d), SLT_10, FWD ? 0 : 4 - d);
        end

        drain();
        issue(LW_8);
        run_consumer("indep", LW_9, 0);

        drain();
        issue(LW_8);
        run_consumer("fwd_sub", SUB_10, FWD ? 1 : 3);
        check("fwd_sub.fwd_a", fwd_a, FWD ? 2'b10 : 2'b00);
        check("fwd_sub.fwd_b", fwd_b, 2'b00);
        run_consumer("fwd_add", ADD_11, FWD ? 0 : 3);
        check("fwd_add.fwd_a", fwd_a, FWD ? 2'b01 : 2'b00);
        check("fwd_add.fwd_b", fwd_b, FWD ? 2'b01 : 2'b00);

        drain();
        ifid_ir = BEQ_10;
        @(posedge clock);
        check("br.t0.ifid_flush", ifid_flush, 0);
        edge_wait();
        ifid_ir = LW_12;
        @(posedge clock);
        check("br.t1.exmem_flush", exmem_flush, 0);
        edge_wait();
        ifid_ir      = SW_12;
        branch_taken = 1'b1;
        @(posedge clock);
        check("br.t2.pc_write", pc_write, 1);
        check("br.t2.ifid_write", ifid_write, 1);
        check("br.t2.bubble", idex_bubble, 1);
        check("br.t2.ifid_flush", ifid_flush, 1);
        check("br.t2.exmem_flush", exmem_flush, 1);
        edge_wait();
        exp_flush++;
        check("br.flush_count", flush_count, exp_flush);
        check("br.stall_count", stall_count, exp_stall);
        branch_taken = 1'b0;
        ifid_ir      = ADD_13;
        @(posedge clock);
        check("br.t3.exmem_flush", exmem_flush, 0);
        check("br.t3.ifid_flush", ifid_flush, 0);
        check("br.t3.pc_write", pc_write, 1);
        edge_wait();
        check("br.t3.stall_count", stall_count, exp_stall);

        drain();
        issue(LW_8);
        issue(SLT_10);
        reset        = 1'b1;
        branch_taken = 1'b1;
        ifid_ir      = SLT_10;
        @(posedge clock);
        check("rstmid.pc_write", pc_write, 1);
        check("rstmid.ifid_write", ifid_write, 1);
        check("rstmid.bubble", idex_bubble, 0);
        check("rstmid.ifid_flush", ifid_flush, 0);
        check("rstmid.exmem_flush", exmem_flush, 0);
        edge_wait();
        check("rstmid.stall_count", stall_count, 0);
        check("rstmid.flush_count", flush_count, 0);
        reset        = 1'b0;
        branch_taken = 1'b0;
        @(posedge clock);
        check("rstmid.after.pc_write", pc_write, 1);
        check("rstmid.after.bubble", idex_bubble, 0);
        edge_wait();
        check("rstmid.after.stall_count", stall_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
